iot_stream_mem_writer: RTL and testbench

//  Upstream feeder for the 2048x32 single-port on-chip RAM.
//  - Accepts a byte stream (valid/ready) and packs it little-endian into 32-bit words.
//  - Writes each word into the RAM over its address/byteenable/chipselect/write port.
//  - Addresses the RAM as a circular buffer and reports write pointer, wrap and end-of-packet status.

---
 rtl/iot_stream_mem_writer.sv | 223 ++++++++++++++++++++++
 tb/tb_iot_stream_mem_writer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iot_stream_mem_writer.sv
// Packs a valid/ready byte stream little-endian into 32-bit words and writes them into a
// circular buffer in single-port RAM. Define IOT_STREAM_MEM_WRITER_VERIFY_EN for read-back checking.
module iot_stream_mem_writer #(
  parameter int ADDR_W      = 11,
  parameter int DEPTH_WORDS = 2048,
  parameter int BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  output logic              mem_clken,
  output logic              mem_reset_req,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wrapped,
  output logic              pkt_done,
  output logic              verify_err,
  output logic [ADDR_W-1:0] err_addr
);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + DEPTH_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_PACK, S_WRITE, S_VRD, S_VCMP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d, cnt_nxt;
  logic [31:0]         data_q, data_d, data_nxt;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                wrapped_q, wrapped_d;
  logic                s_ready_q, s_ready_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [3:0]          mem_byteenable_q, mem_byteenable_d;
  logic                mem_chipselect_q, mem_chipselect_d;
  logic                mem_write_q, mem_write_d;
  logic [31:0]         mem_writedata_q, mem_writedata_d;
  logic                pkt_done_q, pkt_done_d;
  logic                accept, go_wr;
  logic [3:0]          be_nxt;

`ifdef IOT_STREAM_MEM_WRITER_VERIFY_EN
  logic [31:0]         chk_data_q, chk_data_d, chk_mask;
  logic [3:0]          chk_be_q, chk_be_d;
  logic [ADDR_W-1:0]   chk_addr_q, chk_addr_d;
  logic                verify_err_q, verify_err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic                mismatch;
`endif

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    data_d           = data_q;
    last_d           = last_q;
    wr_ptr_d         = wr_ptr_q;
    wrapped_d        = wrapped_q;
    mem_address_d    = '0;
    mem_byteenable_d = '0;
    mem_chipselect_d = 1'b0;
    mem_write_d      = 1'b0;
    mem_writedata_d  = '0;
    pkt_done_d       = 1'b0;

    accept   = (state_q == S_PACK) && s_valid && s_ready_q;
    cnt_nxt  = cnt_q + {2'b00, accept};
    data_nxt = data_q;
    if (accept) data_nxt[8*cnt_q[1:0] +: 8] = s_data;
    // A byte arriving alongside flush/enable-drop is packed before the word is written.
    go_wr = (accept && (cnt_q == 3'd3 || s_last)) ||
            ((flush || !enable) && cnt_nxt != 3'd0);
    case (cnt_nxt)
      3'd1:    be_nxt = 4'h1;
      3'd2:    be_nxt = 4'h3;
      3'd3:    be_nxt = 4'h7;
      3'd4:    be_nxt = 4'hF;
      default: be_nxt = 4'h0;
    endcase

`ifdef IOT_STREAM_MEM_WRITER_VERIFY_EN
    chk_data_d   = chk_data_q;
    chk_be_d     = chk_be_q;
    chk_addr_d   = chk_addr_q;
    verify_err_d = verify_err_q;
    err_addr_d   = err_addr_q;
    for (int i = 0; i < 4; i++) chk_mask[8*i +: 8] = {8{chk_be_q[i]}};
    mismatch = |((mem_readdata ^ chk_data_q) & chk_mask);
`endif

    case (state_q)
      S_IDLE: if (enable) state_d = S_PACK;
      S_PACK: begin
        cnt_d  = cnt_nxt;
        data_d = data_nxt;
        last_d = accept && s_last;
        if (go_wr) begin
          state_d          = S_WRITE;
          mem_address_d    = wr_ptr_q;
          mem_byteenable_d = be_nxt;
          mem_chipselect_d = 1'b1;
          mem_write_d      = 1'b1;
          mem_writedata_d  = data_nxt;
        end else if (!enable) begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (wr_ptr_q == LAST_ADDR) begin
          wr_ptr_d  = FIRST_ADDR;
          wrapped_d = 1'b1;
        end else begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        cnt_d  = '0;
        data_d = '0;
`ifdef IOT_STREAM_MEM_WRITER_VERIFY_EN
        chk_data_d       = mem_writedata_q;
        chk_be_d         = mem_byteenable_q;
        chk_addr_d       = mem_address_q;
        mem_chipselect_d = 1'b1;
        mem_address_d    = mem_address_q;
        state_d          = S_VRD;
`else
        pkt_done_d = last_q;
        last_d     = 1'b0;
        state_d    = enable ? S_PACK : S_IDLE;
`endif
      end
`ifdef IOT_STREAM_MEM_WRITER_VERIFY_EN
      S_VRD: state_d = S_VCMP;
      S_VCMP: begin
        if (mismatch) begin
          verify_err_d = 1'b1;
          if (!verify_err_q) err_addr_d = chk_addr_q;
        end
        pkt_done_d = last_q;
        last_d     = 1'b0;
        state_d    = enable ? S_PACK : S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    s_ready_d = (state_d == S_PACK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      data_q           <= '0;
      last_q           <= 1'b0;
      wr_ptr_q         <= FIRST_ADDR;
      wrapped_q        <= 1'b0;
      s_ready_q        <= 1'b0;
      mem_address_q    <= '0;
      mem_byteenable_q <= '0;
      mem_chipselect_q <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_writedata_q  <= '0;
      pkt_done_q       <= 1'b0;
`ifdef IOT_STREAM_MEM_WRITER_VERIFY_EN
      chk_data_q       <= '0;
      chk_be_q         <= '0;
      chk_addr_q       <= '0;
      verify_err_q     <= 1'b0;
      err_addr_q       <= '0;
`endif
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      data_q           <= data_d;
      last_q           <= last_d;
      wr_ptr_q         <= wr_ptr_d;
      wrapped_q        <= wrapped_d;
      s_ready_q        <= s_ready_d;
      mem_address_q    <= mem_address_d;
      mem_byteenable_q <= mem_byteenable_d;
      mem_chipselect_q <= mem_chipselect_d;
      mem_write_q      <= mem_write_d;
      mem_writedata_q  <= mem_writedata_d;
      pkt_done_q       <= pkt_done_d;
`ifdef IOT_STREAM_MEM_WRITER_VERIFY_EN
      chk_data_q       <= chk_data_d;
      chk_be_q         <= chk_be_d;
      chk_addr_q       <= chk_addr_d;
      verify_err_q     <= verify_err_d;
      err_addr_q       <= err_addr_d;
`endif
    end
  end

  assign s_ready        = s_ready_q;
  assign mem_address    = mem_address_q;
  assign mem_byteenable = mem_byteenable_q;
  assign mem_chipselect = mem_chipselect_q;
  assign mem_write      = mem_write_q;
  assign mem_writedata  = mem_writedata_q;
  assign mem_clken      = 1'b1;
  assign mem_reset_req  = reset;
  assign wr_ptr         = wr_ptr_q;
  assign wrapped        = wrapped_q;
  assign pkt_done       = pkt_done_q;

`ifdef IOT_STREAM_MEM_WRITER_VERIFY_EN
  assign verify_err = verify_err_q;
  assign err_addr   = err_addr_q;
`else
  logic unused_readdata;
  assign unused_readdata = ^mem_readdata;
  assign verify_err      = 1'b0;
  assign err_addr        = '0;
`endif
endmodule

// File: tb/tb_iot_stream_mem_writer.sv
// Randomized self-checking bench for iot_stream_mem_writer: RAM model, write monitor and
// a byte-list-to-word reference model.
module tb_iot_stream_mem_writer;
`ifdef IOT_STREAM_MEM_WRITER_VERIFY_EN
  localparam int PD_LAT = 3;
`else
  localparam int PD_LAT = 1;
`endif

  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, flush = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [10:0] mem_address, wr_ptr, err_addr;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken, mem_reset_req, wrapped, pkt_done, verify_err;
  logic [31:0] mem_writedata, mem_readdata = '0;

  iot_stream_mem_writer dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_clken(mem_clken), .mem_reset_req(mem_reset_req),
    .wr_ptr(wr_ptr), .wrapped(wrapped), .pkt_done(pkt_done),
    .verify_err(verify_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          cyc;
  } wr_t;

  wr_t wq[$];
  wr_t exq[$];
  int  pd_q[$];
  int  cyc = 0;
  int  n_checks = 0, n_pass = 0;
  int  exp_ptr = 0;
  int  corrupt_a = -1, corrupt_b = -1;
  logic [31:0] ram [0:2047];

  // RAM model: byte-lane writes, registered read with optional bit-0 corruption.
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      for (int i = 0; i < 4; i++)
        if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
    end else if (mem_chipselect) begin
      mem_readdata <= ram[mem_address] ^
        (((int'(mem_address) == corrupt_a) || (int'(mem_address) == corrupt_b)) ? 32'd1 : 32'd0);
    end
  end

  always @(negedge clk) begin
    wr_t w;
    cyc++;
    if (mem_chipselect && mem_write) begin
      w.addr = mem_address; w.data = mem_writedata; w.be = mem_byteenable; w.cyc = cyc;
      wq.push_back(w);
    end
    if (pkt_done) pd_q.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int t = 0;
    logic r;
    s_data = b; s_valid = 1'b1; s_last = l;
    do begin
      @(negedge clk); r = s_ready;
      @(posedge clk); #1; t++;
    end while (!r && t < 50);
    if (!r) begin
      n_checks++;
      $display("FAIL send_byte: s_ready never rose within 50 cycles");
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; flush = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    tick(2);
    reset = 1'b0; exp_ptr = 0;
    tick(1);
  endtask

  // Reference: split a packet into <=4-byte words, little-endian, one address each.
  task automatic model_packet(input logic [7:0] bytes[$]);
    wr_t w;
    int k = 0;
    w.data = '0;
    foreach (bytes[i]) begin
      w.data[8*k +: 8] = bytes[i];
      k++;
      if (k == 4 || i == bytes.size() - 1) begin
        w.addr = 11'(exp_ptr); w.be = 4'((1 << k) - 1); w.cyc = 0;
        exq.push_back(w);
        exp_ptr = (exp_ptr + 1) % 2048;
        k = 0; w.data = '0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0;
    tick(2);
    @(negedge clk);
    n_checks++;
    if ({s_ready, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
         wrapped, pkt_done, verify_err, err_addr} !== '0)
      $display("FAIL reset_zero: outputs not all zero (addr=%h be=%h cs=%b wr=%b)",
               mem_address, mem_byteenable, mem_chipselect, mem_write);
    else n_pass++;
    n_checks++;
    if ({mem_clken, mem_reset_req, wr_ptr} !== {1'b1, 1'b1, 11'd0})
      $display("FAIL reset_ones: got clken=%b rstreq=%b wr_ptr=%0d want 1 1 0",
               mem_clken, mem_reset_req, wr_ptr);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0; exp_ptr = 0;
    @(negedge clk);
    n_checks++;
    if (mem_reset_req !== 1'b0) $display("FAIL reset_req_release: got %b want 0", mem_reset_req);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    wq.delete();
    enable = 1'b1;
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    tick(4);
    exp_ptr = 1;
    n_checks++;
    if (wq.size() != 1) $display("FAIL basic_count: got %0d writes want 1", wq.size());
    else begin
      n_pass++;
      n_checks++;
      if ({wq[0].addr, wq[0].data, wq[0].be} !== {11'd0, 32'h44332211, 4'hF})
        $display("FAIL basic_write: got addr=%0d data=%h be=%h want 0 44332211 f",
                 wq[0].addr, wq[0].data, wq[0].be);
      else n_pass++;
    end
    n_checks++;
    if (wr_ptr !== 11'd1) $display("FAIL basic_ptr: got %0d want 1", wr_ptr);
    else n_pass++;
  endtask

  task automatic test_last();
    wq.delete(); pd_q.delete();
    send_byte(8'hAA, 0); send_byte(8'hBB, 1);
    tick(6);
    n_checks++;
    if (wq.size() != 1 || pd_q.size() != 1)
      $display("FAIL last_count: got %0d writes %0d pulses want 1 1", wq.size(), pd_q.size());
    else begin
      n_pass++;
      n_checks++;
      if ({wq[0].addr, wq[0].data, wq[0].be} !== {11'(exp_ptr), 32'h0000BBAA, 4'h3})
        $display("FAIL last_write: got addr=%0d data=%h be=%h want %0d 0000bbaa 3",
                 wq[0].addr, wq[0].data, wq[0].be, exp_ptr);
      else n_pass++;
      n_checks++;
      if (pd_q[0] != wq[0].cyc + PD_LAT)
        $display("FAIL last_pulse_time: got cycle %0d want %0d", pd_q[0], wq[0].cyc + PD_LAT);
      else n_pass++;
    end
    exp_ptr++;
  endtask

  task automatic test_flush();
    wq.delete();
    send_byte(8'h5A, 0);
    flush = 1'b1; tick(1); flush = 1'b0;
    tick(4);
    flush = 1'b1; tick(1); flush = 1'b0;
    tick(4);
    n_checks++;
    if (wq.size() != 1) $display("FAIL flush_count: got %0d writes want 1", wq.size());
    else begin
      n_pass++;
      n_checks++;
      if ({wq[0].addr, wq[0].data, wq[0].be} !== {11'(exp_ptr), 32'h0000005A, 4'h1})
        $display("FAIL flush_write: got addr=%0d data=%h be=%h want %0d 5a 1",
                 wq[0].addr, wq[0].data, wq[0].be, exp_ptr);
      else n_pass++;
    end
    exp_ptr++;
  endtask

  task automatic test_enable_drop();
    wq.delete();
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    enable = 1'b0;
    tick(5);
    n_checks++;
    if (wq.size() != 1 || wq[0].data !== 32'h00000201 || wq[0].be !== 4'h3)
      $display("FAIL enable_drop_write: got %0d writes (first data=%h) want 1 of 00000201/3",
               wq.size(), (wq.size() > 0) ? wq[0].data : 32'h0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b0) $display("FAIL enable_drop_idle: s_ready got %b want 0", s_ready);
    else n_pass++;
    @(posedge clk); #1;
    exp_ptr++;
    enable = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] pk[$];
    int npkt = 12, bad = 0;
    wq.delete(); exq.delete(); pd_q.delete();
    for (int p = 0; p < npkt; p++) begin
      int n = $urandom_range(1, 9);
      pk.delete();
      for (int i = 0; i < n; i++) pk.push_back(8'($urandom));
      model_packet(pk);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
        send_byte(pk[i], i == n - 1);
      end
    end
    tick(6);
    n_checks++;
    if (wq.size() != exq.size()) $display("FAIL random_count: got %0d writes want %0d", wq.size(), exq.size());
    else begin
      n_pass++;
      foreach (exq[i])
        if ({wq[i].addr, wq[i].data, wq[i].be} !== {exq[i].addr, exq[i].data, exq[i].be}) bad++;
      n_checks++;
      if (bad != 0) $display("FAIL random_words: %0d of %0d writes differ from model", bad, exq.size());
      else n_pass++;
    end
    n_checks++;
    if (pd_q.size() != npkt) $display("FAIL random_pkt_done: got %0d pulses want %0d", pd_q.size(), npkt);
    else n_pass++;
    n_checks++;
    if (int'(wr_ptr) != exp_ptr) $display("FAIL random_ptr: got %0d want %0d", wr_ptr, exp_ptr);
    else n_pass++;
  endtask

  task automatic test_midreset();
    wq.delete();
    send_byte(8'h10, 0); send_byte(8'h20, 0); send_byte(8'h30, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wq.size() != 0 || mem_write !== 1'b0) $display("FAIL midreset_nowrite: got %0d writes want 0", wq.size());
    else n_pass++;
    n_checks++;
    if ({s_ready, mem_chipselect, mem_byteenable, wr_ptr, wrapped, pkt_done} !== '0 ||
        mem_clken !== 1'b1 || mem_reset_req !== 1'b1)
      $display("FAIL midreset_state: wr_ptr=%0d s_ready=%b cs=%b want reset values", wr_ptr, s_ready, mem_chipselect);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0; exp_ptr = 0;
    tick(1);
    send_word(32'hCAFEF00D);
    tick(4);
    n_checks++;
    if (wq.size() != 1 || wq[0].addr !== 11'd0 || wq[0].data !== 32'hCAFEF00D)
      $display("FAIL midreset_resume: got %0d writes, first addr=%0d want 1 at 0",
               wq.size(), (wq.size() > 0) ? wq[0].addr : 11'h7FF);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    enable = 1'b1;
    wq.delete();
    for (int i = 0; i < 2047; i++) send_word(32'(i));
    tick(4);
    n_checks++;
    if (wq.size() != 2047 || wq[2046].addr !== 11'd2046 || wr_ptr !== 11'd2047 || wrapped !== 1'b0)
      $display("FAIL wrap_preset: writes=%0d wr_ptr=%0d wrapped=%b want 2047 2047 0", wq.size(), wr_ptr, wrapped);
    else n_pass++;
    wq.delete();
    send_word(32'hDEADBEEF);
    tick(4);
    n_checks++;
    if (wq.size() != 1 || wq[0].addr !== 11'd2047 || wr_ptr !== 11'd0 || wrapped !== 1'b1)
      $display("FAIL wrap_last: writes=%0d wr_ptr=%0d wrapped=%b want 1 at 2047, ptr 0, wrapped 1",
               wq.size(), wr_ptr, wrapped);
    else n_pass++;
    wq.delete();
    send_word(32'h12345678);
    tick(4);
    n_checks++;
    if (wq.size() != 1 || wq[0].addr !== 11'd0)
      $display("FAIL wrap_next: writes=%0d addr=%0d want 1 at 0", wq.size(), (wq.size() > 0) ? wq[0].addr : 11'h7FF);
    else n_pass++;
  endtask

`ifdef IOT_STREAM_MEM_WRITER_VERIFY_EN
  task automatic test_verify();
    do_reset();
    enable = 1'b1; corrupt_a = 5; corrupt_b = -1;
    for (int i = 0; i < 5; i++) send_word($urandom);
    tick(6);
    n_checks++;
    if (verify_err !== 1'b0) $display("FAIL verify_clean: verify_err got %b want 0", verify_err);
    else n_pass++;
    send_word($urandom);
    tick(6);
    n_checks++;
    if (verify_err !== 1'b1 || err_addr !== 11'd5)
      $display("FAIL verify_first: got err=%b addr=%0d want 1 5", verify_err, err_addr);
    else n_pass++;
    corrupt_b = 7;
    send_word($urandom); send_word($urandom);
    tick(6);
    n_checks++;
    if (verify_err !== 1'b1 || err_addr !== 11'd5)
      $display("FAIL verify_sticky: got err=%b addr=%0d want 1 5", verify_err, err_addr);
    else n_pass++;
  endtask
`else
  task automatic test_verify();
    n_checks++;
    if (verify_err !== 1'b0 || err_addr !== 11'd0)
      $display("FAIL verify_off: got err=%b addr=%0d want 0 0", verify_err, err_addr);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_last();
    test_flush();
    test_enable_drop();
    test_random();
    test_midreset();
    test_wrap();
    test_verify();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
